lfsr_rng_bank: RTL and testbench

Parametrised bank of NCH independent Fibonacci LFSR random generators, all seeded from one seed word. It supersedes the fixed six-channel, 20-bit generator. Each channel can advance several bits per clock and exposes a free-running raw output. A shared request/response port returns a uniformly distributed value in [0, req_max] from a chosen channel, using rejection sampling with a bounded-retry fallback. Consumers are the game/display logic that needs random positions and choices.

---
 rtl/lfsr_rng_bank.sv | 170 +++++++++++++++++
 tb/tb_lfsr_rng_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_bank.sv
// Bank of NCH Fibonacci LFSR generators seeded from one word, with a shared
// request port that draws a uniform value in [0, req_max] by rejection sampling.
module lfsr_rng_bank #(
  parameter int             NCH     = 6,
  parameter int             W       = 20,
  parameter logic [W-1:0]   TAPS    = 20'h90000,
  parameter int             STEP    = 8,
  parameter int             OUT_W   = 8,
  parameter int             MAX_TRY = 4,
  localparam int            CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [W-1:0]         seed,
  output logic [NCH*OUT_W-1:0] rand_num,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CW-1:0]        req_ch,
  input  logic [OUT_W-1:0]     req_max,
  output logic                 rsp_valid,
  output logic [OUT_W-1:0]     rsp_data,
  output logic                 rsp_err
);

  localparam int TW = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  // Per-channel seed: rotate the shared word by 3*c, mix in c, never all-zero.
  function automatic logic [W-1:0] chan_seed(input logic [W-1:0] s, input int c);
    int           r;
    logic [W-1:0] v;
    r = (3 * c) % W;
    v = (r == 0) ? s : ((s << r) | (s >> (W - r)));
    v = v ^ W'(c);
    if (v == '0) v = W'(1);
    return v;
  endfunction

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    logic [W-1:0] v;
    v = s;
    for (int i = 0; i < STEP; i++) v = {v[W-2:0], ^(v & TAPS)};
    return v;
  endfunction

  // Smallest 2^k-1 covering v: smear the top set bit downwards.
  function automatic logic [OUT_W-1:0] smear(input logic [OUT_W-1:0] v);
    logic [OUT_W-1:0] m;
    m = v;
    for (int i = 1; i < OUT_W; i++) m = m | (m >> 1);
    return m;
  endfunction

  logic [W-1:0]     sreg_q [NCH];
  logic [W-1:0]     sreg_d [NCH];
  state_t           state_q, state_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [OUT_W-1:0] max_q, max_d;
  logic [OUT_W-1:0] mask_q, mask_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] cand;

  // The active draw channel steps once per cycle even when en is also high.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      sreg_d[c] = sreg_q[c];
      if (load) begin
        sreg_d[c] = chan_seed(seed, c);
      end else if (en || (state_q == DRAW && ch_q == CW'(c))) begin
        sreg_d[c] = lfsr_step(sreg_q[c]);
      end
    end
  end

  // NOTE: the shift registers are flops, not RAM, so each one takes its seed
  // directly in reset; there is no separate initialisation sequence.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rst) sreg_q[c] <= chan_seed(seed, c);
      else      sreg_q[c] <= sreg_d[c];
    end
  end

  always_comb begin
    cand = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_q == CW'(c)) cand = sreg_q[c][OUT_W-1:0] & mask_q;
    end
  end

  // NOTE: every next-state signal gets a hold default before the case, so no
  // path through this block leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    max_d   = max_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          ch_d    = req_ch;
          max_d   = req_max;
          mask_d  = smear(req_max);
          tries_d = '0;
          if (int'(req_ch) >= NCH) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = DRAW;
          end
        end
      end
      DRAW: begin
        if (cand <= max_q) begin
          data_d  = cand;
          state_d = DONE;
        end else if (tries_q == TW'(MAX_TRY - 1)) begin
          data_d  = cand - max_q - OUT_W'(1);
          state_d = DONE;
        end else begin
          tries_d = tries_q + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      max_q   <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      max_q   <= max_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign rand_num[c*OUT_W +: OUT_W] = sreg_q[c][OUT_W-1:0];
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q && (state_q == DONE);

endmodule

// File: tb/tb_lfsr_rng_bank.sv
// Scoreboard bench for lfsr_rng_bank: a behavioural LFSR model predicts raw
// outputs and draw results; a monitor matches responses against the queue.
module tb_lfsr_rng_bank;

  localparam int NCH = 6;
  localparam int W = 20;
  localparam int STEP = 8;
  localparam int OUT_W = 8;
  localparam int MAX_TRY = 4;
  localparam int CW = 3;
  localparam logic [W-1:0] TAPS = 20'h90000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, en, load;
  logic [W-1:0]         seed;
  logic [NCH*OUT_W-1:0] rand_num, rand_num1;
  logic                 req_valid, req_valid1, req_ready, req_ready1;
  logic [CW-1:0]        req_ch;
  logic [OUT_W-1:0]     req_max;
  logic                 rsp_valid, rsp_valid1, rsp_err, rsp_err1;
  logic [OUT_W-1:0]     rsp_data, rsp_data1;

  lfsr_rng_bank #(.NCH(NCH), .W(W), .TAPS(TAPS), .STEP(STEP), .OUT_W(OUT_W),
                  .MAX_TRY(MAX_TRY)) u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed),
    .rand_num(rand_num), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_max(req_max), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err));

  // Single-attempt instance for the fallback path.
  lfsr_rng_bank #(.NCH(NCH), .W(W), .TAPS(TAPS), .STEP(STEP), .OUT_W(OUT_W),
                  .MAX_TRY(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed),
    .rand_num(rand_num1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_ch(req_ch), .req_max(req_max), .rsp_valid(rsp_valid1),
    .rsp_data(rsp_data1), .rsp_err(rsp_err1));

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             err;
    int               lat;
    int               acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_sreg [NCH];

  function automatic logic [W-1:0] m_shift(input logic [W-1:0] v);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < W; i++) if (TAPS[i]) fb = fb ^ v[i];
    return {v[W-2:0], fb};
  endfunction

  function automatic logic [W-1:0] m_adv(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    repeat (STEP) r = m_shift(r);
    return r;
  endfunction

  function automatic logic [W-1:0] m_seed(input logic [W-1:0] s, input int c);
    logic [W-1:0] v;
    v = s;
    for (int k = 0; k < (3 * c) % W; k++) v = {v[W-2:0], v[W-1]};
    v = v ^ W'(c);
    if (v == '0) v = W'(1);
    return v;
  endfunction

  function automatic logic [NCH*OUT_W-1:0] m_rand();
    logic [NCH*OUT_W-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*OUT_W +: OUT_W] = m_sreg[c][OUT_W-1:0];
    return r;
  endfunction

  task automatic m_reseed(input logic [W-1:0] s);
    for (int c = 0; c < NCH; c++) m_sreg[c] = m_seed(s, c);
  endtask

  task automatic m_step_all();
    for (int c = 0; c < NCH; c++) m_sreg[c] = m_adv(m_sreg[c]);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_err", rsp_err, mon_e.err);
        check("rsp_latency", cyc - mon_e.acc + 1, mon_e.lat);
      end
    end
  end

  // ---------------- stimulus (tasks start and end at a negedge) ----------------
  task automatic do_reset(input logic [W-1:0] s);
    seed = s;
    rst  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_reseed(s);
  endtask

  task automatic idle_cycle(input logic e, input logic l, input logic [W-1:0] s);
    en   = e;
    load = l;
    seed = s;
    @(negedge clk);
    if (l)      m_reseed(s);
    else if (e) m_step_all();
    en   = 1'b0;
    load = 1'b0;
    check("rand_num", rand_num, m_rand());
  endtask

  task automatic issue(input int ch, input int mx, input logic e);
    int               acc, lat, mk, cand;
    logic [OUT_W-1:0] d;
    logic             er, found;
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_ch    = CW'(ch);
    req_max   = OUT_W'(mx);
    en        = e;
    acc       = cyc + 1;
    if (e) m_step_all();
    d = '0; er = 1'b0; lat = 1;
    if (ch >= NCH) begin
      er = 1'b1;
    end else begin
      mk = 0;
      while (mk < mx) mk = mk * 2 + 1;
      found = 1'b0;
      for (int t = 0; t < MAX_TRY; t++) begin
        if (!found) begin
          cand = int'(m_sreg[ch][OUT_W-1:0]) & mk;
          for (int c = 0; c < NCH; c++)
            if (c == ch || e) m_sreg[c] = m_adv(m_sreg[c]);
          if (cand <= mx) begin
            d = OUT_W'(cand); lat = t + 2; found = 1'b1;
          end else if (t == MAX_TRY - 1) begin
            d = OUT_W'(cand - mx - 1); lat = t + 2; found = 1'b1;
          end
        end
      end
    end
    if (e) m_step_all();
    sb.push_back('{d, er, lat, acc});
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k <= lat) check("req_ready_busy", req_ready, 0);
    end
    en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected completion at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; seed = 20'hFFFFF;
    req_valid = 1'b0; req_valid1 = 1'b0; req_ch = '0; req_max = '0;
    @(negedge clk);

    // Seed init and reset outputs
    do_reset(20'hFFFFF);
    check("init_ch0", rand_num[7:0], 8'hFF);
    check("init_ch1", rand_num[15:8], 8'hFE);
    check("init_raw", rand_num, m_rand());
    check("init_ready", req_ready, 1);
    check("init_rsp_valid", rsp_valid, 0);
    check("init_rsp_data", rsp_data, 0);
    check("init_rsp_err", rsp_err, 0);

    // Fallback with a single attempt: cand 0xFF > 128 -> 0xFF-128-1 = 126
    req_ch = '0; req_max = 8'd128; req_valid1 = 1'b1;
    @(negedge clk);
    req_valid1 = 1'b0;
    check("fb_not_yet", rsp_valid1, 0);
    @(negedge clk);
    check("fb_valid", rsp_valid1, 1);
    check("fb_data", rsp_data1, 8'd126);
    check("fb_err", rsp_err1, 0);
    @(negedge clk);
    check("fb_ready", req_ready1, 1);
    check("fb_raw_main", rand_num, m_rand());

    // Zero guard and one step
    do_reset('0);
    check("zero_ch0", rand_num[7:0], 8'h01);
    idle_cycle(1'b1, 1'b0, '0);
    check("step_ch0", rand_num[7:0], 8'h00);

    // Full-range draw from seed 0: expect 0x01 after 2 cycles
    do_reset('0);
    issue(0, 255, 1'b0);
    idle_cycle(1'b0, 1'b0, '0);

    // Degenerate bound on every channel, then bad channels
    for (int c = 0; c < NCH; c++) issue(c, 0, 1'($urandom_range(0, 1)));
    issue(7, 10, 1'b0);
    issue(6, 3, 1'b1);
    idle_cycle(1'b0, 1'b0, seed);

    // Reset during DRAW aborts silently
    check("abort_ready", req_ready, 1);
    req_valid = 1'b1; req_ch = 3'd2; req_max = 8'd5;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("abort_no_rsp", rsp_valid, 0);
    check("abort_ready_after", req_ready, 1);
    rst = 1'b1;
    m_reseed(seed);
    idle_cycle(1'b0, 1'b0, seed);
    idle_cycle(1'b1, 1'b0, seed);

    // Randomized draws interleaved with en/load activity
    do_reset(W'($urandom));
    repeat (1000) begin
      int ch, mx;
      ch = $urandom_range(0, 7);
      mx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) : 5;
      issue(ch, mx, 1'($urandom_range(0, 1)));
      idle_cycle(1'b0, 1'b0, seed);
      repeat ($urandom_range(0, 2))
        idle_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), W'($urandom));
    end

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
